// File: rtl/cdac_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdac_loader_if                                                |
// | Purpose  : Bundles the load strobe, DAC word, JTAG ownership flag and    |
// |            the serial DAC pins / status of the threshold DAC loader.     |
// | Ports    : none (signals only)                                           |
// |   master : drives LOAD, DATA, JTAG_OWN; observes DAC pins and status     |
// |   slave  : the loader; consumes the strobe, drives pins and status       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface cdac_loader_if #(
  parameter int WIDTH = 12
) ();
  logic             LOAD;
  logic [WIDTH-1:0] DATA;
  logic             JTAG_OWN;
  logic             DACCLK;
  logic             DACDAT;
  logic             DAC_ENB_B;
  logic             BUSY;
  logic             DONE;
  logic             DROP;
  logic [WIDTH-1:0] LAST_WORD;

  modport master (
    output LOAD, DATA, JTAG_OWN,
    input  DACCLK, DACDAT, DAC_ENB_B, BUSY, DONE, DROP, LAST_WORD
  );

  modport slave (
    input  LOAD, DATA, JTAG_OWN,
    output DACCLK, DACDAT, DAC_ENB_B, BUSY, DONE, DROP, LAST_WORD
  );
endinterface
`default_nettype wire

// File: rtl/cdac_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cdac_loader                                                   |
// | Purpose  : Autonomous MSB-first serial loader for the comparator         |
// |            threshold DAC. Every pin is driven straight from a flop so    |
// |            DACCLK, DACDAT and DAC_ENB_B are glitch-free.                 |
// | Ports    : CLK25  - system clock, all state on its rising edge           |
// |            RST_B  - asynchronous active-low reset                        |
// |            bus    - cdac_loader_if.slave: LOAD/DATA/JTAG_OWN in,         |
// |                     DACCLK/DACDAT/DAC_ENB_B/BUSY/DONE/DROP/LAST_WORD out |
// | Params   : WIDTH (1..32) bits per word, HALF (1..15) CLK25 cycles per    |
// |            DACCLK half-period                                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cdac_loader #(
  parameter int WIDTH = 12,
  parameter int HALF  = 2
) (
  input  logic         CLK25,
  input  logic         RST_B,
  cdac_loader_if.slave bus
);

  localparam int               C_BCW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [4:0]       C_HALF_LAST = 5'(HALF - 1);
  // The trailing hold spans a full DACCLK period, so the enable deasserts
  // 2*HALF*(WIDTH+1) cycles after the load edge.
  localparam logic [4:0]       C_HOLD_LAST = 5'(2 * HALF - 1);
  localparam logic [C_BCW-1:0] C_BC_LAST   = C_BCW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t             r_state,  w_state;
  logic [4:0]         r_hc,     w_hc;
  logic [C_BCW-1:0]   r_bc,     w_bc;
  logic [WIDTH-1:0]   r_sr,     w_sr;
  logic [WIDTH-1:0]   r_word,   w_word;
  logic [WIDTH-1:0]   r_last,   w_last;
  logic               r_dacclk, w_dacclk;
  logic               r_dacdat, w_dacdat;
  logic               r_enb_b,  w_enb_b;
  logic               r_busy,   w_busy;
  logic               r_done,   w_done;
  logic               r_drop,   w_drop;
  logic               w_hc_end;
  logic [WIDTH-1:0]   w_sr_shl;

  assign w_hc_end = (r_hc == C_HALF_LAST);
  assign w_sr_shl = r_sr << 1;

  always_comb begin
    w_state  = r_state;
    w_hc     = r_hc;
    w_bc     = r_bc;
    w_sr     = r_sr;
    w_word   = r_word;
    w_last   = r_last;
    w_dacclk = r_dacclk;
    w_dacdat = r_dacdat;
    w_enb_b  = r_enb_b;
    w_busy   = r_busy;
    w_done   = 1'b0;
    // Any strobe that cannot start a transfer is reported, never queued.
    w_drop   = bus.LOAD && ((r_state != S_IDLE) || bus.JTAG_OWN);

    if ((r_state != S_IDLE) && bus.JTAG_OWN) begin
      // JTAG takes the DAC: release the pins at once, beats any completion.
      w_state  = S_IDLE;
      w_hc     = 5'd0;
      w_bc     = '0;
      w_dacclk = 1'b0;
      w_dacdat = 1'b0;
      w_enb_b  = 1'b1;
      w_busy   = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.LOAD && !bus.JTAG_OWN) begin
            w_sr     = bus.DATA;
            w_word   = bus.DATA;
            w_dacdat = bus.DATA[WIDTH-1];
            w_enb_b  = 1'b0;
            w_busy   = 1'b1;
            w_hc     = 5'd0;
            w_bc     = '0;
            w_state  = S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_hc_end) begin
            w_hc     = 5'd0;
            w_dacclk = 1'b1;
            w_state  = S_SHIFT_HI;
          end else begin
            w_hc = r_hc + 5'd1;
          end
        end
        S_SHIFT_HI: begin
          if (w_hc_end) begin
            w_hc     = 5'd0;
            w_dacclk = 1'b0;
            if (r_bc != C_BC_LAST) begin
              // Next bit changes together with the falling edge, giving a
              // full half-period of setup before the next rising edge.
              w_sr     = w_sr_shl;
              w_dacdat = w_sr_shl[WIDTH-1];
              w_bc     = r_bc + C_BCW'(1);
              w_state  = S_SHIFT_LO;
            end else begin
              w_state = S_HOLD;
            end
          end else begin
            w_hc = r_hc + 5'd1;
          end
        end
        S_SHIFT_LO: begin
          if (w_hc_end) begin
            w_hc     = 5'd0;
            w_dacclk = 1'b1;
            w_state  = S_SHIFT_HI;
          end else begin
            w_hc = r_hc + 5'd1;
          end
        end
        S_HOLD: begin
          if (r_hc == C_HOLD_LAST) begin
            w_hc     = 5'd0;
            w_enb_b  = 1'b1;
            w_dacdat = 1'b0;
            w_busy   = 1'b0;
            w_done   = 1'b1;
            w_last   = r_word;
            w_state  = S_IDLE;
          end else begin
            w_hc = r_hc + 5'd1;
          end
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK25 or negedge RST_B) begin
    if (!RST_B) begin
      r_state  <= S_IDLE;
      r_hc     <= 5'd0;
      r_bc     <= '0;
      r_sr     <= '0;
      r_word   <= '0;
      r_last   <= '0;
      r_dacclk <= 1'b0;
      r_dacdat <= 1'b0;
      r_enb_b  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_hc     <= w_hc;
      r_bc     <= w_bc;
      r_sr     <= w_sr;
      r_word   <= w_word;
      r_last   <= w_last;
      r_dacclk <= w_dacclk;
      r_dacdat <= w_dacdat;
      r_enb_b  <= w_enb_b;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_drop   <= w_drop;
    end
  end

  assign bus.DACCLK    = r_dacclk;
  assign bus.DACDAT    = r_dacdat;
  assign bus.DAC_ENB_B = r_enb_b;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.DROP      = r_drop;
  assign bus.LAST_WORD = r_last;

endmodule
`default_nettype wire
